// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between the execute (EX)
// and load (LD) writeback sources. It grants one writeback per cycle, registers the
// winning write onto rf_*, and keeps a pending-write busy bitmap for the issue stage.
// Optional feature macro: WB_ARB_RR_EN selects round-robin arbitration instead of
// fixed LD priority with an EX starvation guard.
module regfile_wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int NREG         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [4:0]      ex_rd,
    input  logic [XLEN-1:0] ex_data,
    output logic            ex_ready,
    input  logic            ld_valid,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    output logic            ld_ready,
    input  logic            rsv_valid,
    input  logic [4:0]      rsv_rd,
    output logic            rf_w_en,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_write_data,
    output logic [NREG-1:0] busy
);

    logic            w_exGrant;
    logic            w_ldGrant;
    logic            w_exPriority;
    logic            r_rfWen;
    logic [4:0]      r_rfRd;
    logic [XLEN-1:0] r_rfData;
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busyNext;

`ifdef WB_ARB_RR_EN
    // Set when EX should win the next contested cycle; LD is favoured after reset.
    logic r_exPriority;

    // Round-robin pointer: whoever was granted last loses the next contested cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_exPriority <= 1'b0;
        end else if (w_exGrant) begin
            r_exPriority <= 1'b0;
        end else if (w_ldGrant) begin
            r_exPriority <= 1'b1;
        end
    end

    assign w_exPriority = r_exPriority;
`else
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic [SW-1:0] r_starveCount;

    // Count contested losses of EX, saturating at the limit; any EX grant clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starveCount <= '0;
        end else if (w_exGrant) begin
            r_starveCount <= '0;
        end else if (ex_valid && w_ldGrant && (r_starveCount != LIMIT)) begin
            r_starveCount <= r_starveCount + 1'b1;
        end
    end

    assign w_exPriority = (r_starveCount == LIMIT);
`endif

    // Pick at most one requester per cycle; nothing is granted while reset is held.
    always_comb begin
        w_exGrant = 1'b0;
        w_ldGrant = 1'b0;
        if (!rst) begin
            if (ex_valid && ld_valid) begin
                if (w_exPriority) begin
                    w_exGrant = 1'b1;
                end else begin
                    w_ldGrant = 1'b1;
                end
            end else begin
                w_exGrant = ex_valid;
                w_ldGrant = ld_valid;
            end
        end
    end

    assign ex_ready = w_exGrant;
    assign ld_ready = w_ldGrant;

    // Register the granted write; x0 writes are swallowed and rd/data hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rfWen  <= 1'b0;
            r_rfRd   <= '0;
            r_rfData <= '0;
        end else begin
            r_rfWen <= 1'b0;
            if (w_exGrant && (ex_rd != 5'd0)) begin
                r_rfWen  <= 1'b1;
                r_rfRd   <= ex_rd;
                r_rfData <= ex_data;
            end else if (w_ldGrant && (ld_rd != 5'd0)) begin
                r_rfWen  <= 1'b1;
                r_rfRd   <= ld_rd;
                r_rfData <= ld_data;
            end
        end
    end

    // Next busy bitmap: clear on the commit edge, then a new reservation overrides it.
    always_comb begin
        w_busyNext = r_busy;
        if (r_rfWen) begin
            w_busyNext[r_rfRd] = 1'b0;
        end
        if (rsv_valid && (rsv_rd != 5'd0)) begin
            w_busyNext[rsv_rd] = 1'b1;
        end
        w_busyNext[0] = 1'b0;
    end

    // Busy bitmap flops, driven straight to the issue stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busyNext;
        end
    end

    assign rf_w_en       = r_rfWen;
    assign rf_rd         = r_rfRd;
    assign rf_write_data = r_rfData;
    assign busy          = r_busy;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed scenarios plus a randomized run checked against a
// behavioural model of the writeback arbiter (grant rules, write latency, busy bitmap).
module tb_regfile_wb_arbiter;

    localparam int LIMIT = 4;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic [31:0] ex_data;
    logic        ex_ready;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        rsv_valid;
    logic [4:0]  rsv_rd;
    logic        rf_w_en;
    logic [4:0]  rf_rd;
    logic [31:0] rf_write_data;
    logic [31:0] busy;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit [31:0] mBusy;
    bit        mWen;
    bit [4:0]  mRd;
    bit [31:0] mData;
    int        mStarve;
    bit        mLastEx;

    regfile_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_data(ex_data), .ex_ready(ex_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .rsv_valid(rsv_valid), .rsv_rd(rsv_rd),
        .rf_w_en(rf_w_en), .rf_rd(rf_rd), .rf_write_data(rf_write_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected grant pair {ex, ld} from the arbitration rules
    function automatic bit [1:0] modelGrant(input bit r, input bit ev, input bit lv);
        bit exWins;
        if (r) return 2'b00;
        if (ev && !lv) return 2'b10;
        if (lv && !ev) return 2'b01;
        if (!ev && !lv) return 2'b00;
`ifdef WB_ARB_RR_EN
        exWins = !mLastEx;
`else
        exWins = (mStarve >= LIMIT);
`endif
        return exWins ? 2'b10 : 2'b01;
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic modelUpdate();
        bit [1:0] g;
        if (rst) begin
            mBusy = 0; mWen = 0; mRd = 0; mData = 0; mStarve = 0; mLastEx = 1;
            return;
        end
        g = modelGrant(rst, ex_valid, ld_valid);
        if (mWen) mBusy[mRd] = 1'b0;
        if (rsv_valid && rsv_rd != 0) mBusy[rsv_rd] = 1'b1;
        mBusy[0] = 1'b0;
        mWen = 0;
        if (g[1] && ex_rd != 0) begin
            mWen = 1; mRd = ex_rd; mData = ex_data;
        end else if (g[0] && ld_rd != 0) begin
            mWen = 1; mRd = ld_rd; mData = ld_data;
        end
        if (g[1]) mStarve = 0;
        else if (g[0] && ex_valid) mStarve = (mStarve + 1 > LIMIT) ? LIMIT : mStarve + 1;
        if (g[1]) mLastEx = 1;
        if (g[0]) mLastEx = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        modelUpdate();
        #1;
    endtask

    task automatic applyStimulus(input bit ev, input bit [4:0] er, input bit [31:0] ed,
                                 input bit lv, input bit [4:0] lr, input bit [31:0] ldd,
                                 input bit rv, input bit [4:0] rr);
        ex_valid = ev; ex_rd = er; ex_data = ed;
        ld_valid = lv; ld_rd = lr; ld_data = ldd;
        rsv_valid = rv; rsv_rd = rr;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        applyStimulus(1, 3, 32'h1111, 1, 4, 32'h2222, 1, 9);
        @(negedge clk);
        checks++;
        if ({ex_ready, ld_ready} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b required 00", {ex_ready, ld_ready});
        end
        tick();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if ({rf_w_en, rf_rd, rf_write_data, busy} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state: got wen=%b rd=%0d data=%h busy=%h required all zero",
                     rf_w_en, rf_rd, rf_write_data, busy);
        end
        tick();
    endtask

    task automatic test_single_ex();
        doReset();
        applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if ({ex_ready, ld_ready} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL single_ex_ready: got %b required 10", {ex_ready, ld_ready});
        end
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if ({rf_w_en, rf_rd, rf_write_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            errors++;
            $display("[TB] FAIL single_ex_write: got wen=%b rd=%0d data=%h required 1/5/deadbeef",
                     rf_w_en, rf_rd, rf_write_data);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({rf_w_en, rf_rd, rf_write_data} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
            errors++;
            $display("[TB] FAIL single_ex_hold: got wen=%b rd=%0d data=%h required 0/5/deadbeef",
                     rf_w_en, rf_rd, rf_write_data);
        end
        tick();
    endtask

    task automatic test_contention();
        bit [1:0]  expSeq [6];
        bit [1:0]  got;
        bit [4:0]  prevRd;
        bit [31:0] prevData;
        bit [31:0] exD;
        bit [31:0] ldD;
`ifdef WB_ARB_RR_EN
        expSeq = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`else
        expSeq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
`endif
        doReset();
        exD = 32'hE000_0000;
        ldD = 32'hA000_0000;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(i < 6, 2, exD, i < 6, 1, ldD, 0, 0);
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if ({rf_w_en, rf_rd, rf_write_data} !== {1'b1, prevRd, prevData}) begin
                    errors++;
                    $display("[TB] FAIL contention_write[%0d]: got wen=%b rd=%0d data=%h required 1/%0d/%h",
                             i, rf_w_en, rf_rd, rf_write_data, prevRd, prevData);
                end
            end
            if (i < 6) begin
                got = {ex_ready, ld_ready};
                checks++;
                if (got !== expSeq[i]) begin
                    errors++;
                    $display("[TB] FAIL contention_grant[%0d]: got %b required %b", i, got, expSeq[i]);
                end
                if (expSeq[i][1]) begin
                    prevRd = 2; prevData = exD;
                end else begin
                    prevRd = 1; prevData = ldD;
                end
            end
            tick();
            if (i < 6 && expSeq[i][1]) exD++;
            if (i < 6 && expSeq[i][0]) ldD++;
        end
    endtask

    task automatic test_scoreboard();
        doReset();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 7);
        tick();
        applyStimulus(0, 0, 0, 1, 7, 32'h7777_0007, 0, 0);
        @(negedge clk);
        checks++;
        if (busy !== 32'h0000_0080) begin
            errors++;
            $display("[TB] FAIL sb_set: got busy=%h required 00000080", busy);
        end
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if ({rf_w_en, rf_rd, busy} !== {1'b1, 5'd7, 32'h0000_0080}) begin
            errors++;
            $display("[TB] FAIL sb_pending: got wen=%b rd=%0d busy=%h required 1/7/00000080",
                     rf_w_en, rf_rd, busy);
        end
        tick();
        @(negedge clk);
        checks++;
        if (busy !== 32'h0) begin
            errors++;
            $display("[TB] FAIL sb_clear: got busy=%h required 00000000", busy);
        end
        tick();
    endtask

    task automatic test_collision();
        doReset();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 7);
        tick();
        applyStimulus(0, 0, 0, 1, 7, 32'h0000_CAFE, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 7);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (busy !== 32'h0000_0080) begin
            errors++;
            $display("[TB] FAIL collision_busy: got busy=%h required 00000080", busy);
        end
        tick();
    endtask

    task automatic test_x0();
        doReset();
        applyStimulus(1, 0, 32'h1234_5678, 0, 0, 0, 1, 0);
        @(negedge clk);
        checks++;
        if (ex_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL x0_ready: got %b required 1", ex_ready);
        end
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if ({rf_w_en, busy} !== 33'h0) begin
            errors++;
            $display("[TB] FAIL x0_effect: got wen=%b busy=%h required 0/00000000", rf_w_en, busy);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        doReset();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 7);
        tick();
        applyStimulus(1, 3, 32'h3333, 1, 4, 32'h4444, 0, 0);
        @(negedge clk);
        checks++;
        if (busy !== 32'h0000_00A0) begin
            errors++;
            $display("[TB] FAIL midreset_pre: got busy=%h required 000000a0", busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({ex_ready, ld_ready} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL midreset_ready: got %b required 00", {ex_ready, ld_ready});
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, rf_w_en, ex_ready, ld_ready} !== {32'h0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL midreset_post: got busy=%h wen=%b ex_rdy=%b ld_rdy=%b required 0/0/0/1",
                     busy, rf_w_en, ex_ready, ld_ready);
        end
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_random();
        bit        exPend, ldPend;
        bit [4:0]  exR, ldR;
        bit [31:0] exD, ldD;
        bit [1:0]  g;
        doReset();
        exPend = 0; ldPend = 0;
        exR = 0; ldR = 0; exD = 0; ldD = 0;
        for (int i = 0; i < 600; i++) begin
            if (!exPend && $urandom_range(0, 3) != 0) begin
                exPend = 1; exR = 5'($urandom_range(0, 31)); exD = $urandom;
            end
            if (!ldPend && $urandom_range(0, 2) != 0) begin
                ldPend = 1; ldR = 5'($urandom_range(0, 31)); ldD = $urandom;
            end
            rst = ($urandom_range(0, 79) == 0);
            applyStimulus(exPend, exR, exD, ldPend, ldR, ldD,
                          $urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)));
            @(negedge clk);
            g = modelGrant(rst, ex_valid, ld_valid);
            checks++;
            if ({ex_ready, ld_ready} !== g) begin
                errors++;
                $display("[TB] FAIL rand_grant[%0d]: got %b required %b", i, {ex_ready, ld_ready}, g);
            end
            checks++;
            if ({rf_w_en, rf_rd, rf_write_data} !== {mWen, mRd, mData}) begin
                errors++;
                $display("[TB] FAIL rand_write[%0d]: got wen=%b rd=%0d data=%h required %b/%0d/%h",
                         i, rf_w_en, rf_rd, rf_write_data, mWen, mRd, mData);
            end
            checks++;
            if (busy !== mBusy) begin
                errors++;
                $display("[TB] FAIL rand_busy[%0d]: got %h required %h", i, busy, mBusy);
            end
            tick();
            if (g[1] || rst) exPend = 0;
            if (g[0] || rst) ldPend = 0;
        end
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        mBusy = 0; mWen = 0; mRd = 0; mData = 0; mStarve = 0; mLastEx = 1;
        #1;
        test_reset();
        test_single_ex();
        test_contention();
        test_scoreboard();
        test_collision();
        test_x0();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
